// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, bubble default and skid-register state encoding
package cpu_pkg;

  localparam logic [3:0] OPCODE_ADD = 4'h0;
  localparam logic [3:0] OPCODE_SUB = 4'h1;
  localparam logic [3:0] OPCODE_AND = 4'h2;
  localparam logic [3:0] OPCODE_OR  = 4'h3;
  localparam logic [3:0] OPCODE_XOR = 4'h4;
  localparam logic [3:0] OPCODE_SLL = 4'h5;
  localparam logic [3:0] OPCODE_SRL = 4'h6;
  localparam logic [3:0] OPCODE_SRA = 4'h7;
  localparam logic [3:0] OPCODE_SLT = 4'h8;
  localparam logic [3:0] OPCODE_LD  = 4'h9;
  localparam logic [3:0] OPCODE_ST  = 4'hA;
  localparam logic [3:0] OPCODE_BEQ = 4'hB;
  localparam logic [3:0] OPCODE_BNE = 4'hC;
  localparam logic [3:0] OPCODE_JAL = 4'hD;
  localparam logic [3:0] OPCODE_JR  = 4'hE;
  localparam logic [3:0] OPCODE_HLT = 4'hF;

  // Opcode presented downstream when no entry is held.
  localparam logic [3:0] BUBBLE_OP_DEFAULT = 4'h0;

  // State encoding doubles as the occupancy count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef enum logic [1:0] {
    STATE_EMPTY = ST_EMPTY,
    STATE_HALF  = ST_HALF,
    STATE_FULL  = ST_FULL
  } skid_state_t;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one pipeline entry: valid bit plus opcode/payload register
// Ports: clk, rst (sync, active-high, clears valid and data), clr (drops valid only),
//        load (captures d and sets valid), d (entry in), valid/q (entry out).
module pipe_slot #(
  parameter int W = 68
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_register.sv
// rtl/pipe_skid_register.sv - valid/ready pipeline register with optional two-entry skid buffer
// Ports: clk, rst (sync active-high), flush (drop all entries),
//        in_valid/in_ready/in_opcode/in_data (upstream beat),
//        out_valid/out_ready/out_opcode/out_data (head entry, gated to bubble when empty),
//        occupancy (entries held).
module pipe_skid_register
  import cpu_pkg::*;
#(
  parameter int              DATA_W    = 64,
  parameter int              OP_W      = 4,
  parameter logic [OP_W-1:0] BUBBLE_OP = BUBBLE_OP_DEFAULT,
  parameter bit              SKID      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_opcode,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam int SW = OP_W + DATA_W;

  logic          accept;
  logic          consume;
  logic          main_load;
  logic          main_clr;
  logic          main_valid;
  logic [SW-1:0] main_d;
  logic [SW-1:0] main_q;

  assign accept  = in_valid & in_ready;
  assign consume = main_valid & out_ready;

  // Output mux sits on register outputs only; a bubble carries a harmless opcode and zero data.
  assign out_valid  = main_valid;
  assign out_opcode = main_valid ? main_q[SW-1 -: OP_W] : BUBBLE_OP;
  assign out_data   = main_valid ? main_q[DATA_W-1:0] : '0;

  pipe_slot #(.W(SW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .clr   (main_clr),
    .load  (main_load),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  generate
    if (SKID) begin : g_skid
      skid_state_t   state;
      skid_state_t   state_nxt;
      logic          skid_load;
      logic          skid_clr;
      logic          skid_valid;
      logic [SW-1:0] skid_q;

      // in_ready comes from state alone, so downstream stalls never reach upstream combinationally.
      assign in_ready  = ~rst & (state != STATE_FULL);
      assign occupancy = state;
      // Skid is only valid in FULL, where main refills from it; otherwise main takes the input.
      assign main_d    = skid_valid ? skid_q : {in_opcode, in_data};

      always_ff @(posedge clk) begin
        if (rst) state <= STATE_EMPTY;
        else     state <= state_nxt;
      end

      always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        if (flush) begin
          state_nxt = STATE_EMPTY;
          main_clr  = 1'b1;
          skid_clr  = 1'b1;
        end else begin
          case (state)
            STATE_EMPTY: begin
              if (accept) begin
                state_nxt = STATE_HALF;
                main_load = 1'b1;
              end
            end
            STATE_HALF: begin
              if (accept && consume) begin
                main_load = 1'b1;
              end else if (accept) begin
                state_nxt = STATE_FULL;
                skid_load = 1'b1;
              end else if (consume) begin
                state_nxt = STATE_EMPTY;
                main_clr  = 1'b1;
              end
            end
            STATE_FULL: begin
              if (consume) begin
                state_nxt = STATE_HALF;
                main_load = 1'b1;
                skid_clr  = 1'b1;
              end
            end
            default: begin
              state_nxt = STATE_EMPTY;
              main_clr  = 1'b1;
              skid_clr  = 1'b1;
            end
          endcase
        end
      end

      pipe_slot #(.W(SW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clr   (skid_clr),
        .load  (skid_load),
        .d     ({in_opcode, in_data}),
        .valid (skid_valid),
        .q     (skid_q)
      );
    end else begin : g_single
      // Single entry can refill in the same cycle its head leaves, hence the out_ready term.
      assign in_ready  = ~rst & (out_ready | ~main_valid);
      assign occupancy = {1'b0, main_valid};
      assign main_d    = {in_opcode, in_data};

      always_comb begin
        main_load = accept;
        main_clr  = flush | (consume & ~accept);
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_skid_register.sv
// tb/tb_pipe_skid_register.sv - randomized and directed bench for pipe_skid_register (SKID=1 and SKID=0)
module tb_pipe_skid_register;

  localparam int DATA_W = 64;
  localparam int OP_W   = 4;
  localparam logic [OP_W-1:0] BUB1 = 4'h0;
  localparam logic [OP_W-1:0] BUB0 = 4'hE;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic [OP_W-1:0]   in_opcode = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_ready = 1'b0;

  logic              in_ready1, out_valid1, in_ready0, out_valid0;
  logic [OP_W-1:0]   out_opcode1, out_opcode0;
  logic [DATA_W-1:0] out_data1, out_data0;
  logic [1:0]        occupancy1, occupancy0;

  int vectors = 0;
  int miscompares = 0;

  beat_t q1[$];
  beat_t q0[$];

  pipe_skid_register #(.DATA_W(DATA_W), .OP_W(OP_W), .BUBBLE_OP(BUB1), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_opcode(in_opcode), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_opcode(out_opcode1), .out_data(out_data1),
    .occupancy(occupancy1)
  );

  pipe_skid_register #(.DATA_W(DATA_W), .OP_W(OP_W), .BUBBLE_OP(BUB0), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_opcode(in_opcode), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_opcode(out_opcode0), .out_data(out_data0),
    .occupancy(occupancy0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks current outputs against the queue models, then advances the models by one edge.
  task automatic cycle();
    logic  rdy1, rdy0, acc1, acc0, con1, con0;
    beat_t b;
    #1;
    rdy1 = !rst && (q1.size() < 2);
    rdy0 = !rst && (out_ready || q0.size() == 0);
    chk("s1_in_ready",   in_ready1,  rdy1);
    chk("s1_out_valid",  out_valid1, q1.size() > 0);
    chk("s1_out_opcode", out_opcode1, (q1.size() > 0) ? q1[0].op : BUB1);
    chk("s1_out_data",   out_data1,   (q1.size() > 0) ? q1[0].data : 64'd0);
    chk("s1_occupancy",  occupancy1,  q1.size());
    chk("s0_in_ready",   in_ready0,  rdy0);
    chk("s0_out_valid",  out_valid0, q0.size() > 0);
    chk("s0_out_opcode", out_opcode0, (q0.size() > 0) ? q0[0].op : BUB0);
    chk("s0_out_data",   out_data0,   (q0.size() > 0) ? q0[0].data : 64'd0);
    chk("s0_occupancy",  occupancy0,  q0.size());
    b.op   = in_opcode;
    b.data = in_data;
    acc1 = in_valid && rdy1;
    acc0 = in_valid && rdy0;
    con1 = out_ready && q1.size() > 0;
    con0 = out_ready && q0.size() > 0;
    if (rst || flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (con1) void'(q1.pop_front());
      if (acc1) q1.push_back(b);
      if (con0) void'(q0.pop_front());
      if (acc0) q0.push_back(b);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [OP_W-1:0] op, input logic [DATA_W-1:0] d,
                       input logic ordy);
    in_valid  = v;
    in_opcode = op;
    in_data   = d;
    out_ready = ordy;
  endtask

  initial begin
    @(posedge clk);
    @(negedge clk);

    // Reset held for two cycles, then idle.
    rst = 1'b1; drive(1'b1, 4'h7, 64'h1234, 1'b1);
    cycle();
    cycle();
    rst = 1'b0; drive(1'b0, 4'h0, 64'h0, 1'b0);
    cycle();

    // Streaming with out_ready held high.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, OP_W'(i), DATA_W'(i), 1'b1);
      cycle();
    end
    drive(1'b0, 4'h0, 64'h0, 1'b1);
    cycle();
    cycle();

    // Back-pressure: A held, B fills skid, then drain.
    drive(1'b1, 4'h2, 64'hAAAA, 1'b0);
    cycle();
    drive(1'b1, 4'h3, 64'hBBBB, 1'b0);
    cycle();
    drive(1'b0, 4'h0, 64'h0, 1'b0);
    cycle();
    drive(1'b0, 4'h0, 64'h0, 1'b1);
    cycle();
    cycle();
    cycle();

    // Flush while FULL, with C offered in the same cycle.
    drive(1'b1, 4'h2, 64'hAAAA, 1'b0);
    cycle();
    drive(1'b1, 4'h3, 64'hBBBB, 1'b0);
    cycle();
    flush = 1'b1; drive(1'b1, 4'h4, 64'hCCCC, 1'b1);
    cycle();
    flush = 1'b0; drive(1'b0, 4'h0, 64'h0, 1'b1);
    cycle();
    cycle();

    // rst and flush together with a beat offered.
    drive(1'b1, 4'h9, 64'h9999, 1'b0);
    cycle();
    rst = 1'b1; flush = 1'b1; drive(1'b1, 4'hA, 64'hEEEE, 1'b0);
    cycle();
    rst = 1'b0; flush = 1'b0; drive(1'b0, 4'h0, 64'h0, 1'b0);
    cycle();

    // Single-entry behaviour: D held blocks E, then D leaves and E enters back-to-back.
    drive(1'b1, 4'hD, 64'hDDDD, 1'b0);
    cycle();
    drive(1'b1, 4'hE, 64'hEEEE, 1'b0);
    cycle();
    drive(1'b1, 4'hE, 64'hEEEE, 1'b1);
    cycle();
    drive(1'b0, 4'h0, 64'h0, 1'b1);
    cycle();
    cycle();

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) < 65), OP_W'($urandom), {$urandom, $urandom},
            ($urandom_range(0, 99) < 55));
      flush = ($urandom_range(0, 99) < 3);
      rst   = ($urandom_range(0, 199) < 2);
      cycle();
    end
    rst = 1'b0; flush = 1'b0; drive(1'b0, 4'h0, 64'h0, 1'b1);
    cycle();
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
